// File: rtl/aes_inv_subbytes.sv
// AES inverse SubBytes over a 16-byte state with a valid/ready handshake.
// Byte k of the state occupies bits [8k+7:8k].
// Default build: serial datapath with 4 inverse S-boxes, one 4-byte group
// per BUSY cycle, so the result is ready 4 cycles after the accept edge.
// Define AES_INV_SUBBYTES_PARALLEL_EN for the parallel datapath: 16 inverse
// S-boxes and IDLE->DONE directly on the accept edge.

// Inverse S-box computed directly: inverse affine map, then GF(2^8) inverse.
module aes_inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 = x^-1 for x != 0; yields 0 for x == 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] r;
    sq = x;
    r  = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] aff;

  // Inverse affine transform followed by the field inverse.
  always_comb begin
    aff = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
    y_o = gf_inv(aff);
  end

endmodule

module aes_inv_subbytes (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e       state_q, state_d;
  logic [127:0] res_q, res_d;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_state = (state_q == DONE) ? res_q : '0;

`ifdef AES_INV_SUBBYTES_PARALLEL_EN

  logic [127:0] sub_all;

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .a_i (in_state[8*g +: 8]),
      .y_o (sub_all[8*g +: 8])
    );
  end

  // Whole state substituted on the accept edge; the result register is the capture register.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        res_d   = sub_all;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
    end
  end

`else

  logic [127:0] in_q, in_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [31:0]  grp_in, grp_out;

  assign grp_in = in_q[{cnt_q, 5'b0} +: 32];

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .a_i (grp_in[8*g +: 8]),
      .y_o (grp_out[8*g +: 8])
    );
  end

  // Capture on accept, then substitute one 4-byte group per BUSY cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    in_d    = in_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        in_d    = in_state;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        res_d[{cnt_q, 5'b0} +: 32] = grp_out;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter, input and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_q    <= in_d;
      res_q   <= res_d;
    end
  end

`endif

endmodule

// File: tb/tb_aes_inv_subbytes.sv
// Self-checking bench for aes_inv_subbytes; reference inverse S-box is built
// from log/antilog tables of GF(2^8) and the forward AES affine map.
module tb_aes_inv_subbytes;

`ifdef AES_INV_SUBBYTES_PARALLEL_EN
  localparam int unsigned LAT = 0;  // edges after the accept edge until out_valid is seen
`else
  localparam int unsigned LAT = 4;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [7:0] sbox_t   [256];
  logic [7:0] isbox_t  [256];
  logic [7:0] alog_t   [256];
  int unsigned log_t   [256];

  aes_inv_subbytes dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] rotl(input logic [7:0] x, input int unsigned n);
    logic [15:0] w;
    w = {x, x} << n;
    return w[15:8];
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    logic [7:0] x2;
    x2 = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    return x2 ^ b;
  endfunction

  // Generator 3 enumerates all nonzero field elements; inverse via logs.
  task automatic build_model();
    logic [7:0] inv;
    alog_t[0] = 8'h01;
    for (int i = 1; i < 256; i++) alog_t[i] = mul3(alog_t[i-1]);
    for (int i = 0; i < 255; i++) log_t[alog_t[i]] = i;
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : alog_t[(255 - log_t[x]) % 255];
      sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);
  endtask

  function automatic logic [127:0] ref_state(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = isbox_t[s[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, wait for result, check latency and hold, then take it.
  task automatic xfer(input logic [127:0] data, output logic [127:0] res);
    int unsigned n;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk("ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_state = data;
    step();
    in_valid = 1'b0;
    in_state = rnd128();
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    chk("latency", n, LAT);
    chk("no_ready_in_done", in_ready, 0);
    res = out_state;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("ready_after_take", in_ready, 1);
    chk("zero_out_when_idle", out_state, '0);
  endtask

  logic [127:0] res, d, held;
  logic [7:0]   spot_in  [6];
  logic [7:0]   spot_out [6];

  initial begin
    build_model();
    spot_in  = '{8'h63, 8'h7c, 8'h16, 8'hed, 8'h00, 8'h53};
    spot_out = '{8'h00, 8'h01, 8'hff, 8'h53, 8'h52, 8'h50};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_state", out_state, '0);

    // Known-answer fills, including all bytes 8'h63 -> 8'h00.
    for (int i = 0; i < 6; i++) begin
      xfer(fill(spot_in[i]), res);
      chk("spot_fill", res, fill(spot_out[i]));
    end

    // Byte ordering across groups: byte k = Sbox(k).
    for (int k = 0; k < 16; k++) d[8*k +: 8] = sbox_t[k];
    xfer(d, res);
    chk("byte_order", res, 128'h0f0e0d0c0b0a09080706050403020100);

    // Every byte value, 16 bytes alike.
    for (int v = 0; v < 256; v++) begin
      xfer(fill(sbox_t[v]), res);
      chk("all_values", res, fill(8'(v)));
    end

    // Random states against the model.
    for (int i = 0; i < 24; i++) begin
      d = rnd128();
      xfer(d, res);
      chk("random", res, ref_state(d));
    end

    // Backpressure: result held for 5 cycles with out_ready low.
    d = rnd128();
    in_valid = 1'b1; in_state = d;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) step();
    held = out_state;
    chk("bp_first", held, ref_state(d));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_stable", out_state, held);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_ready", in_ready, 1);

    // Input traffic while busy must not disturb the captured state.
    d = rnd128();
    in_valid = 1'b1; in_state = d;
    step();
    for (int i = 0; i < 6; i++) begin
      in_valid = (i % 2 == 0);
      in_state = rnd128();
      step();
    end
    in_valid = 1'b0;
    chk("busy_ignore_valid", out_valid, 1);
    chk("busy_ignore_data", out_state, ref_state(d));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset mid-operation (counter at 2 in the serial build).
    in_valid = 1'b1; in_state = rnd128();
    step();
    in_valid = 1'b0;
    if (LAT >= 2) begin step(); step(); end
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy_low", busy, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("abort_no_valid", out_valid, 0);
    end
    xfer(fill(8'h63), res);
    chk("abort_fresh", res, fill(8'h00));

    // Reset and in_valid together: nothing accepted.
    rst = 1'b1; in_valid = 1'b1; in_state = fill(8'h63);
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rstvalid_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rstvalid_no_valid", out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
